// File: rtl/multdiv_unit_pkg.sv
// Shared processor constants for the execute-stage multiply/divide unit:
// ALU opcodes, FSM state encodings and default widths.
package multdiv_unit_pkg;

   localparam logic [4:0] ALUOP_MUL = 5'b00110;
   localparam logic [4:0] ALUOP_DIV = 5'b00111;

   localparam int DATA_WIDTH_DEF = 32;
   localparam int CNT_WIDTH_DEF  = 6;
   localparam int TAG_WIDTH_DEF  = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/multdiv_unit_if.sv
// Start/operand/result bundle between decode, the mul/div unit and writeback.
interface multdiv_unit_if #(
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 5
);
   logic                  ctrl_MULT;
   logic                  ctrl_DIV;
   logic [DATA_WIDTH-1:0] data_operandA;
   logic [DATA_WIDTH-1:0] data_operandB;
   logic [TAG_WIDTH-1:0]  tag_in;
   logic [DATA_WIDTH-1:0] data_result;
   logic                  data_exception;
   logic                  data_resultRDY;
   logic [TAG_WIDTH-1:0]  tag_out;
   logic                  busy;

   modport master (
      output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, tag_in,
      input  data_result, data_exception, data_resultRDY, tag_out, busy
   );

   modport slave (
      input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, tag_in,
      output data_result, data_exception, data_resultRDY, tag_out, busy
   );
endinterface

// File: rtl/multdiv_unit_negate_32.sv
// Conditional two's-complement negation, used for operand magnitudes and
// for restoring the sign of the final result.
module negate_32 #(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] value,
   input  logic                  negate_en,
   output logic [DATA_WIDTH-1:0] result
);
   assign result = negate_en ? (~value + {{(DATA_WIDTH-1){1'b0}}, 1'b1}) : value;
endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (shift-add) / divide (restoring) unit: one bit per
// clock over DATA_WIDTH clocks, registered result handed to writeback.
module multdiv_unit
   import multdiv_unit_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
   parameter int TAG_WIDTH  = TAG_WIDTH_DEF
) (
   input  logic          clock,
   input  logic          reset,
   multdiv_unit_if.slave bus
);
   localparam int W = DATA_WIDTH;
   localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t               state_r;
   logic [CNT_WIDTH-1:0] cnt_r;
   logic [W-1:0]         op_r;      // multiplicand (MUL) or divisor (DIV) magnitude
   logic [2*W-1:0]       acc_r;     // {acc_hi, multiplier} or {remainder, quotient}
   logic                 sign_r;
   logic [TAG_WIDTH-1:0] tag_r;
   logic [W-1:0]         result_r;
   logic                 exc_r;
   logic                 rdy_r;
   logic [TAG_WIDTH-1:0] tag_out_r;

   logic           start_s;
   logic           start_mul_s;
   logic [W-1:0]   a_mag_s;
   logic [W-1:0]   b_mag_s;
   logic [W-1:0]   res_signed_s;
   logic [2*W-1:0] acc_nx_s;
   logic [W:0]     sum_s;
   logic [W+1:0]   diff_s;
   logic           last_s;
   logic           mul_ovf_s;
   logic           div_ovf_s;

   assign start_s     = (bus.ctrl_MULT | bus.ctrl_DIV) &
                        ((state_r == ST_IDLE) | (state_r == ST_DONE));
   assign start_mul_s = start_s & bus.ctrl_MULT;
   assign last_s      = (cnt_r == LAST_CNT);

   negate_32 #(.DATA_WIDTH(W)) u_neg_a (
      .value(bus.data_operandA), .negate_en(bus.data_operandA[W-1]), .result(a_mag_s)
   );
   negate_32 #(.DATA_WIDTH(W)) u_neg_b (
      .value(bus.data_operandB), .negate_en(bus.data_operandB[W-1]), .result(b_mag_s)
   );
   negate_32 #(.DATA_WIDTH(W)) u_neg_res (
      .value(acc_nx_s[W-1:0]), .negate_en(sign_r), .result(res_signed_s)
   );

   // One shift-add or restoring-divide step on the accumulator
   always_comb begin
      sum_s    = '0;
      diff_s   = '0;
      acc_nx_s = acc_r;
      case (state_r)
         ST_MUL: begin
            sum_s    = {1'b0, acc_r[2*W-1:W]} + {1'b0, (acc_r[0] ? op_r : {W{1'b0}})};
            acc_nx_s = {sum_s, acc_r[W-1:1]};
         end
         ST_DIV: begin
            diff_s = {1'b0, acc_r[2*W-1:W-1]} - {2'b00, op_r};
            if (!diff_s[W+1]) begin
               acc_nx_s = {diff_s[W-1:0], acc_r[W-2:0], 1'b1};
            end else begin
               acc_nx_s = {acc_r[2*W-2:0], 1'b0};
            end
         end
         default: begin
            acc_nx_s = acc_r;
         end
      endcase
   end

   // A signed product fits in W bits iff its magnitude is below 2^(W-1), or equals it when negative
   assign mul_ovf_s = sign_r ? ((|acc_nx_s[2*W-1:W]) | (acc_nx_s[W-1] & (|acc_nx_s[W-2:0])))
                             : (|acc_nx_s[2*W-1:W-1]);
   // Positive quotient of 2^(W-1) only arises from INT_MIN / -1
   assign div_ovf_s = ~sign_r & acc_nx_s[W-1];

   // Control FSM, datapath registers and registered writeback outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r   <= ST_IDLE;
         cnt_r     <= '0;
         op_r      <= '0;
         acc_r     <= '0;
         sign_r    <= 1'b0;
         tag_r     <= '0;
         result_r  <= '0;
         exc_r     <= 1'b0;
         rdy_r     <= 1'b0;
         tag_out_r <= '0;
      end else begin
         rdy_r <= 1'b0;
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (start_s) begin
                  cnt_r  <= '0;
                  sign_r <= bus.data_operandA[W-1] ^ bus.data_operandB[W-1];
                  tag_r  <= bus.tag_in;
                  if (start_mul_s) begin
                     op_r    <= a_mag_s;
                     acc_r   <= {{W{1'b0}}, b_mag_s};
                     state_r <= ST_MUL;
                  end else if (bus.data_operandB == {W{1'b0}}) begin
                     op_r      <= '0;
                     acc_r     <= '0;
                     state_r   <= ST_DONE;
                     result_r  <= '0;
                     exc_r     <= 1'b1;
                     rdy_r     <= 1'b1;
                     tag_out_r <= bus.tag_in;
                  end else begin
                     op_r    <= b_mag_s;
                     acc_r   <= {{W{1'b0}}, a_mag_s};
                     state_r <= ST_DIV;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_MUL, ST_DIV: begin
               acc_r <= acc_nx_s;
               cnt_r <= cnt_r + CNT_ONE;
               if (last_s) begin
                  state_r   <= ST_DONE;
                  rdy_r     <= 1'b1;
                  tag_out_r <= tag_r;
                  if (state_r == ST_MUL) begin
                     result_r <= res_signed_s;
                     exc_r    <= mul_ovf_s;
                  end else if (div_ovf_s) begin
                     result_r <= '0;
                     exc_r    <= 1'b1;
                  end else begin
                     result_r <= res_signed_s;
                     exc_r    <= 1'b0;
                  end
               end else begin
                  state_r <= state_r;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.data_result    = result_r;
   assign bus.data_exception = exc_r;
   assign bus.data_resultRDY = rdy_r;
   assign bus.tag_out        = tag_out_r;
   assign bus.busy           = (state_r == ST_MUL) | (state_r == ST_DIV) | start_s;

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Iterative signed 32-bit multiply/divide unit in the execute stage, directly downstream of the decode control logic.
- Started when the decoded instruction is an ALU op with ALUOp 00110 (mul) or 00111 (div).
- Runs a radix-2 shift-add multiply or restoring divide over 32 iterations.
- Returns the result, exception flag and destination-register tag to writeback.
- Drives `busy` so the pipeline holds the F/D and D/X latches until the result is ready.

Parameters:
- DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH.
- CNT_WIDTH, 6, iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.
- TAG_WIDTH, 5, destination register tag width.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- ctrl_MULT  input  1  start a multiply; one-cycle pulse.
- ctrl_DIV  input  1  start a divide; one-cycle pulse.
- data_operandA  input  32  multiplicand / dividend, two's complement.
- data_operandB  input  32  multiplier / divisor, two's complement.
- tag_in  input  5  destination register of the mul/div instruction.
- data_result  output  32  product low word or quotient; valid only while data_resultRDY=1.
- data_exception  output  1  overflow or divide-by-zero; valid only while data_resultRDY=1.
- data_resultRDY  output  1  one-cycle pulse marking the result valid.
- tag_out  output  5  tag_in captured at start; valid while data_resultRDY=1.
- busy  output  1  combinational: (state is MUL or DIV) OR accepted start this cycle; pipeline stall request.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counter=0; data_result=0, data_exception=0, data_resultRDY=0, tag_out=0; all datapath registers cleared.
- Reset asserted mid-operation aborts the operation; no RDY pulse is produced.
- States: IDLE, MUL, DIV, DONE.
- Start acceptance:
  - A start is accepted only in IDLE or DONE.
  - ctrl_MULT and ctrl_DIV together: multiply wins; ctrl_DIV is ignored.
  - Starts in MUL or DIV are ignored, with no effect on state or outputs.
- On the accepting edge (cycle 0):
  - Latch |A|, |B|, the result sign (signA XOR signB) and tag_in; clear the accumulator and counter=0.
  - Go to MUL or DIV.
- Divide-by-zero (B=0 at start): go straight to DONE with result=0, exception=1; RDY in cycle 1.
- MUL iteration (one per clock, 32 clocks):
  - If the multiplier LSB is 1, add the 32-bit multiplicand into the upper half of a 64-bit accumulator, using a 33-bit sum.
  - Then shift the {carry, accumulator} right 1.
  - counter+1; after the iteration with counter=31, go to DONE.
- DIV iteration (restoring, 32 clocks):
  - Shift {remainder, quotient} left 1.
  - Trial-subtract |B| from the 33-bit remainder.
  - If non-negative, keep the difference and set the quotient LSB to 1; else restore.
  - counter+1; after counter=31, go to DONE.
- Entering DONE (registered outputs):
  - Result = sign ? -magnitude : magnitude. Division truncates toward zero; the remainder is discarded.
  - Multiply exception = 1 when the signed 64-bit product is not the sign extension of its low 32 bits. The result is still the low 32 bits.
  - INT_MIN / -1: exception=1, result=0.
- Latency:
  - data_resultRDY=1 in exactly cycle 33, counting the start cycle as cycle 0. The exception is divide-by-zero (cycle 1).
  - busy is high for cycles 0..32 and low in cycle 33.
- DONE lasts one cycle, then returns to IDLE; data_resultRDY falls to 0.
- A start accepted in DONE begins a new operation the next cycle.
- data_result, data_exception and tag_out hold their values until the next DONE.
- Zero operands need no special-casing: 0×X=0, 0/X=0.

Decomposition:
- Shared package (processor constants file):
  - ALUOP_MUL=5'b00110, ALUOP_DIV=5'b00111.
  - State encodings: IDLE=2'd0, MUL=2'd1, DIV=2'd2, DONE=2'd3.
  - DATA_WIDTH/TAG_WIDTH defaults.
- One sub-module is natural: `negate_32`, a conditional two's-complement negation. It is instanced for the |A| and |B| conversion and for the final sign fix-up.
- The FSM and datapath stay in multdiv_unit.

Test Plan:
- MULT 6 × 7, tag_in=5'd9 → busy cycles 0–32, then cycle 33: RDY=1, result=0x0000002A, exception=0, tag_out=9; a single RDY pulse.
- MULT −5 × 3, then 0x00010000 × 0x00010000 → result 0xFFFFFFF1 with exception=0; then result 0x00000000 with exception=1.
- DIV 100 / −7, then INT_MIN / −1 → result 0xFFFFFFF2 (−14) with exception=0; then result 0 with exception=1; both RDY in cycle 33.
- DIV 5 / 0 → cycle 1: RDY=1, result=0, exception=1; busy high only in cycle 0.
- Start ignored and back-to-back:
  - Start MULT 2×3; in cycle 10 pulse ctrl_DIV 9/3 → the DIV is ignored, and cycle 33 gives result 6.
  - A DIV 9/3 started in cycle 33 → RDY in cycle 66 with result 3.
- Start MULT 6×7 and pull reset low in cycle 15 for 1 cycle → all outputs 0 immediately, state IDLE, no RDY pulse in cycle 33. A following DIV 8/2 completes normally with result 4.
